// File: rtl/alu_op_sequencer.sv
// Multi-cycle ALU initiator: gathers operands from the bus, lets the combinational ALU settle,
// captures the 64-bit result and returns it as one or two valid/ready beats.
module alu_op_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned MULDIV_CYCLES = 4
) (
  input  logic        clock_i,
  input  logic        clear_ni,
  input  logic        start_i,
  input  logic [4:0]  opcode_in_i,
  input  logic [31:0] bus_in_i,
  input  logic        bus_valid_i,
  output logic [31:0] alu_a_o,
  output logic [31:0] alu_b_o,
  output logic [4:0]  alu_opcode_o,
  input  logic [63:0] alu_result_i,
  output logic [31:0] out_data_o,
  output logic        out_hi_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  typedef enum logic [2:0] {
    StIdle, StGetA, StGetB, StExec, StCapture, StSendLo, StSendHi, StDone
  } state_e;

  localparam logic [4:0] OpNot = 5'd2;
  localparam logic [4:0] OpNeg = 5'd3;
  localparam logic [4:0] OpMul = 5'd6;
  localparam logic [4:0] OpDiv = 5'd7;
  localparam logic [4:0] OpMax = 5'd12;

  // Counter runs N-1 down to 0 so EXEC lasts exactly N cycles.
  localparam logic [3:0] SettleLoad = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] MuldivLoad = 4'(MULDIV_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [4:0]  op_q, op_d;
  logic [31:0] z_lo_q, z_lo_d;
  logic [31:0] z_hi_q, z_hi_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, err_d;

  logic       is_muldiv;
  logic       is_unary;
  logic [3:0] exec_load;

  assign is_muldiv = (op_q == OpMul) || (op_q == OpDiv);
  assign is_unary  = (op_q == OpNot) || (op_q == OpNeg);
  assign exec_load = is_muldiv ? MuldivLoad : SettleLoad;

  assign alu_a_o      = a_q;
  assign alu_b_o      = b_q;
  assign alu_opcode_o = op_q;

  always_ff @(posedge clock_i or negedge clear_ni) begin
    if (!clear_ni) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      z_lo_q  <= '0;
      z_hi_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      z_lo_q  <= z_lo_d;
      z_hi_q  <= z_hi_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    z_lo_d      = z_lo_q;
    z_hi_d      = z_hi_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    out_data_o  = '0;
    out_hi_o    = 1'b0;
    out_valid_o = 1'b0;
    done_o      = 1'b0;
    err_o       = 1'b0;
    busy_o      = (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        if (start_i && (opcode_in_i <= OpMax)) begin
          op_d    = opcode_in_i;
          state_d = StGetA;
        end
      end
      StGetA: begin
        if (bus_valid_i) begin
          a_d = bus_in_i;
          if (is_unary) begin
            b_d     = '0;
            cnt_d   = exec_load;
            state_d = StExec;
          end else begin
            state_d = StGetB;
          end
        end
      end
      StGetB: begin
        if (bus_valid_i) begin
          b_d     = bus_in_i;
          cnt_d   = exec_load;
          state_d = StExec;
        end
      end
      StExec: begin
        if (cnt_q == 4'd0) begin
          state_d = StCapture;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StCapture: begin
        // Divide by zero produces no beats; the flag is reported with done.
        if ((op_q == OpDiv) && (b_q == '0)) begin
          z_lo_d  = '0;
          z_hi_d  = '0;
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          z_lo_d  = alu_result_i[31:0];
          z_hi_d  = is_muldiv ? alu_result_i[63:32] : '0;
          state_d = StSendLo;
        end
      end
      StSendLo: begin
        out_valid_o = 1'b1;
        out_data_o  = z_lo_q;
        if (out_ready_i) begin
          state_d = is_muldiv ? StSendHi : StDone;
        end
      end
      StSendHi: begin
        out_valid_o = 1'b1;
        out_data_o  = z_hi_q;
        out_hi_o    = 1'b1;
        if (out_ready_i) begin
          state_d = StDone;
        end
      end
      StDone: begin
        done_o  = 1'b1;
        err_o   = err_q;
        err_d   = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized bench for alu_op_sequencer: models the external ALU and checks each transaction's
// beats, flags and timing against expectations derived from the operation rules.
module tb_alu_op_sequencer;

  localparam int unsigned Settle = 1;
  localparam int unsigned Muldiv = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  opcode_in;
  logic [31:0] bus_in;
  logic        bus_valid;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_opcode;
  logic [63:0] alu_result;
  logic [31:0] out_data;
  logic        out_hi;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(
    .SETTLE_CYCLES(Settle),
    .MULDIV_CYCLES(Muldiv)
  ) u_dut (
    .clock_i      (clk),
    .clear_ni     (rst_n),
    .start_i      (start),
    .opcode_in_i  (opcode_in),
    .bus_in_i     (bus_in),
    .bus_valid_i  (bus_valid),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_opcode_o (alu_opcode),
    .alu_result_i (alu_result),
    .out_data_o   (out_data),
    .out_hi_o     (out_hi),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err)
  );

  // External ALU; single-width ops carry junk in the upper word, which must never surface.
  function automatic logic [63:0] alu_fn(input logic [4:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [31:0] r;
    logic [63:0] w;
    logic [4:0]  s;
    s = b[4:0];
    r = 32'h0;
    case (op)
      5'd0: r = a & b;
      5'd1: r = a | b;
      5'd2: r = ~a;
      5'd3: r = -a;
      5'd4: r = a + b;
      5'd5: r = a - b;
      5'd6: return {32'h0, a} * {32'h0, b};
      5'd7: begin
        if (b == 32'h0) return 64'hDEAD_BEEF_CAFE_F00D;
        return {a % b, a / b};
      end
      5'd8: r = a >> s;
      5'd9: r = $signed(a) >>> s;
      5'd10: r = a << s;
      5'd11: begin w = {a, a} >> s; r = w[31:0]; end
      5'd12: begin w = {a, a} << s; r = w[63:32]; end
      default: r = 32'h0;
    endcase
    return {~a ^ b, r};
  endfunction

  assign alu_result = alu_fn(alu_opcode, alu_a, alu_b);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // rdy_mode: 0 ready always, 1 random ready, 2 ready low for the first 5 valid cycles.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int rdy_mode, input bit fullv, input bit noise,
                        output logic [31:0] beat0);
    logic [31:0] opnd [2];
    logic [31:0] got_d [$];
    logic        got_h [$];
    logic [31:0] exp_d [2];
    logic [63:0] full;
    logic [31:0] hold_d;
    logic        hold_h;
    int nop, nexec, nexp, k, c_last, t_first, t_done, t_hs, n_stall;
    bit md, div0, stall_prev, got_err, err_stray, busy_bad;
    opnd[0]    = a;
    opnd[1]    = b;
    md         = (op == 5'd6) || (op == 5'd7);
    nop        = ((op == 5'd2) || (op == 5'd3)) ? 1 : 2;
    nexec      = md ? Muldiv : Settle;
    div0       = (op == 5'd7) && (b == 32'h0);
    full       = alu_fn(op, a, (nop == 1) ? 32'h0 : b);
    exp_d[0]   = full[31:0];
    exp_d[1]   = full[63:32];
    nexp       = div0 ? 0 : (md ? 2 : 1);
    k          = 0;
    c_last     = -1;
    t_first    = -1;
    t_done     = -1;
    t_hs       = -1;
    n_stall    = 0;
    stall_prev = 1'b0;
    got_err    = 1'b0;
    err_stray  = 1'b0;
    busy_bad   = 1'b0;
    hold_d     = 32'h0;
    hold_h     = 1'b0;

    @(posedge clk); #1;
    start     = 1'b1;
    opcode_in = op;
    bus_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 300 && t_done < 0; cyc++) begin
      if (k < nop) begin
        bus_valid = fullv || ($urandom_range(0, 2) != 0);
        bus_in    = bus_valid ? opnd[k] : $urandom();
      end else begin
        bus_valid = 1'($urandom_range(0, 1));
        bus_in    = $urandom();
      end
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 2) == 0);
        default: out_ready = (t_first > 0) && (cyc - t_first >= 5);
      endcase
      if (noise) begin
        start     = 1'($urandom_range(0, 1));
        opcode_in = 5'($urandom());
      end
      @(negedge clk);
      if (!busy) busy_bad = 1'b1;
      if (err && !done) err_stray = 1'b1;
      if (stall_prev) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, hold_d);
        check("hold_hi", out_hi, hold_h);
        n_stall++;
      end
      if (out_valid) begin
        if (t_first < 0) t_first = cyc;
        if (out_ready) begin
          got_d.push_back(out_data);
          got_h.push_back(out_hi);
          t_hs = cyc;
        end
      end
      stall_prev = out_valid && !out_ready;
      hold_d     = out_data;
      hold_h     = out_hi;
      if (done) begin
        t_done  = cyc;
        got_err = err;
        check("held_a", alu_a, a);
        check("held_b", alu_b, (nop == 1) ? 32'h0 : b);
        check("held_op", alu_opcode, op);
      end
      if (k < nop && bus_valid) begin
        k++;
        if (k == nop) c_last = cyc;
      end
      if (t_done < 0) begin
        @(posedge clk); #1;
      end
    end
    start = 1'b0;

    if (t_done < 0) check("timeout", 0, 1);
    check("n_beats", got_d.size(), nexp);
    for (int i = 0; i < got_d.size() && i < nexp; i++) begin
      check("beat_data", got_d[i], exp_d[i]);
      check("beat_hi", got_h[i], i);
    end
    check("err", got_err, div0);
    check("err_stray", err_stray, 0);
    check("busy", busy_bad, 0);
    if (t_done > 0 && c_last > 0) begin
      check("latency", (div0 ? t_done : t_first) - c_last, nexec + 2);
      if (!div0) check("done_after_beat", t_done - t_hs, 1);
    end
    if (rdy_mode == 2) check("stall_cycles", n_stall, 5);
    beat0 = (got_d.size() > 0) ? got_d[0] : 32'h0;
  endtask

  task automatic illegal_start();
    bit bad;
    bad = 1'b0;
    @(posedge clk); #1;
    start     = 1'b1;
    opcode_in = 5'(13 + $urandom_range(0, 18));
    repeat (4) begin
      @(negedge clk);
      if (busy || done || err || out_valid) bad = 1'b1;
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("illegal_opcode", bad, 0);
  endtask

  task automatic reset_mid_op();
    bit bad;
    bad = 1'b0;
    @(posedge clk); #1;
    start     = 1'b1;
    opcode_in = 5'd6;
    @(posedge clk); #1;
    start     = 1'b0;
    bus_valid = 1'b1;
    bus_in    = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    bus_in = 32'h2;
    @(posedge clk); #1;
    bus_valid = 1'b0;
    @(posedge clk); #3;
    check("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_ab", {alu_a, alu_b}, 64'h0);
    check("async_rst_misc", {alu_opcode, out_data, out_hi, out_valid, busy, done, err}, 64'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (busy || done || err || out_valid) bad = 1'b1;
    end
    check("post_reset_quiet", bad, 0);
  endtask

  initial begin
    logic [31:0] bt;
    rst_n     = 1'b0;
    start     = 1'b0;
    opcode_in = 5'd0;
    bus_in    = 32'h0;
    bus_valid = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ab", {alu_a, alu_b}, 64'h0);
    check("rst_misc", {alu_opcode, out_data, out_hi, out_valid, busy, done, err}, 64'h0);
    rst_n = 1'b1;

    run_op(5'd4, 32'h5, 32'h3, 0, 1'b1, 1'b0, bt);
    check("add_plan", bt, 32'h8);
    run_op(5'd6, 32'hFFFF_FFFF, 32'h2, 0, 1'b1, 1'b0, bt);
    check("mul_plan_lo", bt, 32'hFFFF_FFFE);
    run_op(5'd2, 32'h0F0F_0F0F, 32'h1234_5678, 0, 1'b1, 1'b0, bt);
    check("not_plan", bt, 32'hF0F0_F0F0);
    illegal_start();
    run_op(5'd7, 32'h10, 32'h0, 0, 1'b1, 1'b0, bt);
    run_op(5'd4, 32'h5, 32'h3, 0, 1'b1, 1'b0, bt);
    check("add_after_div0", bt, 32'h8);
    run_op(5'd11, 32'h1, 32'h1, 2, 1'b1, 1'b1, bt);
    check("ror_plan", bt, 32'h8000_0000);
    reset_mid_op();
    run_op(5'd5, 32'h7, 32'h9, 0, 1'b1, 1'b0, bt);
    check("sub_plan", bt, 32'hFFFF_FFFE);

    for (int n = 0; n < 200; n++) begin
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 5'($urandom_range(0, 12));
      a  = $urandom();
      b  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom();
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      run_op(op, a, b, $urandom_range(0, 2), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), bt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
